// File: rtl/dae_pkg.sv
// Shared definitions for the dae_pipe decode/execute unit.
// Opcode encodings are fixed because the instruction sequencer emits raw 3-bit codes.
package dae_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_ROL = 3'b100,
    OP_ASR = 3'b101,
    OP_EQ  = 3'b110,
    OP_GT  = 3'b111
  } dae_op_e;

endpackage

// File: rtl/dae_alu.sv
// Combinational eight-op ALU for dae_pipe, parametrised by datapath width.
// carry carries the ADD carry-out or the SUB borrow; it is 0 for every other op.
module dae_alu
  import dae_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  dae_op_e          sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  // The extra top bit of the difference is set exactly when a < b (unsigned borrow).
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (sel)
      OP_ADD: begin
        y     = w_sum[WIDTH-1:0];
        carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        y     = w_diff[WIDTH-1:0];
        carry = w_diff[WIDTH];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ROL:  y = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ASR:  y = {b[WIDTH-1], b[WIDTH-1:1]};
      OP_EQ:   y = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_GT:   y = {{(WIDTH-1){1'b0}}, (a > b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/dae_pipe.sv
// Two-stage decode/execute unit: D latches an instruction, E reads the register file,
// computes, writes back and presents the result on a held valid/ready output.
module dae_pipe
  import dae_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREG  = 4,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  input  logic [AW-1:0]    in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_rd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  logic [WIDTH-1:0] r_rf [NREG];

  logic             r_d_valid;
  dae_op_e          r_d_sel;
  logic [AW-1:0]    r_d_rs;
  logic [AW-1:0]    r_d_rt;
  logic [AW-1:0]    r_d_rd;

  logic             r_out_valid;
  logic [AW-1:0]    r_out_rd;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_carry;

  logic             w_e_adv;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_wb_en;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_alu_y;
  logic             w_alu_carry;

  // E may advance whenever the output slot is empty or being consumed this edge.
  assign w_e_adv    = !r_out_valid || out_ready;
  assign w_in_ready = !r_d_valid || w_e_adv;
  assign w_in_fire  = in_valid && w_in_ready;
  assign w_wb_en    = r_d_valid && w_e_adv;

  assign w_op_a = r_rf[r_d_rs];
  assign w_op_b = r_rf[r_d_rt];

  dae_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .sel   (r_d_sel),
    .a     (w_op_a),
    .b     (w_op_b),
    .y     (w_alu_y),
    .carry (w_alu_carry)
  );

  // Writeback is assigned last so it overrides a same-address load on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      if (ld_en) begin
        r_rf[ld_addr] <= ld_data;
      end
      if (w_wb_en) begin
        r_rf[r_d_rd] <= w_alu_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_valid <= 1'b0;
      r_d_sel   <= OP_ADD;
      r_d_rs    <= '0;
      r_d_rt    <= '0;
      r_d_rd    <= '0;
    end else if (w_in_fire) begin
      r_d_valid <= 1'b1;
      r_d_sel   <= dae_op_e'(in_sel);
      r_d_rs    <= in_rs;
      r_d_rt    <= in_rt;
      r_d_rd    <= in_rd;
    end else if (w_e_adv) begin
      r_d_valid <= 1'b0;
    end
  end

  // Output fields only change on an advancing edge, so they stay frozen during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_rd    <= '0;
      r_out_data  <= '0;
      r_out_carry <= 1'b0;
    end else if (w_e_adv) begin
      r_out_valid <= r_d_valid;
      if (r_d_valid) begin
        r_out_rd    <= r_d_rd;
        r_out_data  <= w_alu_y;
        r_out_carry <= w_alu_carry;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_rd    = r_out_rd;
  assign out_data  = r_out_data;
  assign out_carry = r_out_carry;

endmodule

// File: tb/tb_dae_pipe.sv
// Directed bench for dae_pipe: a WIDTH=4 and a WIDTH=8 instance share control inputs,
// results are checked against hand values and an integer reference model.
module tb_dae_pipe;
  import dae_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_d4;
  logic [7:0] ld_d8;
  logic       in_valid;
  logic [2:0] in_sel;
  logic [1:0] in_rs, in_rt, in_rd;
  logic       out_ready;

  logic       rdy4, ov4, oc4;
  logic [1:0] ord4;
  logic [3:0] od4;
  logic       rdy8, ov8, oc8;
  logic [1:0] ord8;
  logic [7:0] od8;

  logic [3:0] cap_d4;
  logic       cap_c4;
  logic [1:0] cap_rd4;
  logic [7:0] cap_d8;
  logic       cap_c8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dae_pipe #(.WIDTH(4), .NREG(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_d4),
    .in_valid(in_valid), .in_ready(rdy4), .in_sel(in_sel), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .out_valid(ov4), .out_ready(out_ready), .out_rd(ord4),
    .out_data(od4), .out_carry(oc4)
  );

  dae_pipe #(.WIDTH(8), .NREG(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_d8),
    .in_valid(in_valid), .in_ready(rdy8), .in_sel(in_sel), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .out_valid(ov8), .out_ready(out_ready), .out_rd(ord8),
    .out_data(od8), .out_carry(oc8)
  );

  // Reference model written with integer arithmetic; returns {carry, y[7:0]}.
  function automatic logic [8:0] model(input int w, input int op, input int a, input int b);
    int mask, y, c;
    mask = (1 << w) - 1;
    c = 0;
    case (op)
      0: begin y = a + b; c = (y >> w) & 1; end
      1: begin y = a - b; c = (a < b) ? 1 : 0; end
      2: y = a & b;
      3: y = a | b;
      4: y = (a << 1) | (a >> (w - 1));
      5: y = (b >> 1) | (b & (1 << (w - 1)));
      6: y = (a == b) ? 1 : 0;
      default: y = (a > b) ? 1 : 0;
    endcase
    y = y & mask;
    return {c[0], y[7:0]};
  endfunction

  // Called on a negedge; returns on the negedge after the load edge.
  task automatic load(input logic [1:0] addr, input logic [3:0] d4, input logic [7:0] d8);
    ld_en = 1'b1; ld_addr = addr; ld_d4 = d4; ld_d8 = d8;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Issues one instruction into an empty pipe with out_ready=1, captures the result,
  // and returns once the result has been consumed. lat counts edges after the accept edge.
  task automatic exec(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rt,
                      input logic [1:0] rd, output int lat);
    in_valid = 1'b1; in_sel = op; in_rs = rs; in_rt = rt; in_rd = rd;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!ov4 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    cap_d4 = od4; cap_c4 = oc4; cap_rd4 = ord4; cap_d8 = od8; cap_c8 = oc8;
    $display("[TB] op=%0d rs=%0d rt=%0d rd=%0d lat=%0d w4=%h/%b w8=%h/%b",
             op, rs, rt, rd, lat, cap_d4, cap_c4, cap_d8, cap_c8);
    @(negedge clk);
  endtask

  task automatic test_reset;
    int lat;
    n_tests++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", rdy4); end
    n_tests++; if (ov4 !== 1'b0 || ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b/%b want 0", ov4, ov8); end
    n_tests++; if (od4 !== 4'd0 || oc4 !== 1'b0 || ord4 !== 2'd0) begin n_fail++; $display("FAIL reset_outputs got d=%h c=%b rd=%0d want 0", od4, oc4, ord4); end
    exec(OP_OR, 2'd0, 2'd1, 2'd0, lat);
    n_tests++; if (cap_d4 !== 4'd0 || cap_d8 !== 8'd0) begin n_fail++; $display("FAIL reset_rf01 got %h/%h want 0", cap_d4, cap_d8); end
    exec(OP_OR, 2'd2, 2'd3, 2'd2, lat);
    n_tests++; if (cap_d4 !== 4'd0 || cap_d8 !== 8'd0) begin n_fail++; $display("FAIL reset_rf23 got %h/%h want 0", cap_d4, cap_d8); end
  endtask

  task automatic test_arith;
    int lat;
    load(2'd1, 4'd7, 8'd7);
    load(2'd2, 4'd3, 8'd3);
    exec(OP_ADD, 2'd1, 2'd2, 2'd3, lat);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d want 1", lat); end
    n_tests++; if (cap_d4 !== 4'd10 || cap_c4 !== 1'b0 || cap_rd4 !== 2'd3) begin n_fail++; $display("FAIL add_w4 got d=%0d c=%b rd=%0d want 10 0 3", cap_d4, cap_c4, cap_rd4); end
    n_tests++; if (cap_d8 !== 8'd10 || cap_c8 !== 1'b0) begin n_fail++; $display("FAIL add_w8 got %h/%b want 0a/0", cap_d8, cap_c8); end
    exec(OP_SUB, 2'd2, 2'd1, 2'd0, lat);
    n_tests++; if (cap_d4 !== 4'd12 || cap_c4 !== 1'b1 || cap_rd4 !== 2'd0) begin n_fail++; $display("FAIL sub_w4 got d=%0d c=%b rd=%0d want 12 1 0", cap_d4, cap_c4, cap_rd4); end
    n_tests++; if (cap_d8 !== 8'hfc || cap_c8 !== 1'b1) begin n_fail++; $display("FAIL sub_w8 got %h/%b want fc/1", cap_d8, cap_c8); end
  endtask

  task automatic test_logic_shift;
    int lat;
    load(2'd1, 4'b1001, 8'h89);
    load(2'd2, 4'b1000, 8'h88);
    exec(OP_ROL, 2'd1, 2'd0, 2'd0, lat);
    n_tests++; if (cap_d4 !== 4'b0011 || cap_d8 !== 8'h13) begin n_fail++; $display("FAIL rol got %b/%h want 0011/13", cap_d4, cap_d8); end
    exec(OP_ASR, 2'd0, 2'd2, 2'd0, lat);
    n_tests++; if (cap_d4 !== 4'b1100 || cap_d8 !== 8'hc4) begin n_fail++; $display("FAIL asr got %b/%h want 1100/c4", cap_d4, cap_d8); end
    exec(OP_EQ, 2'd1, 2'd1, 2'd0, lat);
    n_tests++; if (cap_d4 !== 4'd1 || cap_d8 !== 8'd1 || cap_c4 !== 1'b0) begin n_fail++; $display("FAIL eq got %h/%h c=%b want 1/1 c=0", cap_d4, cap_d8, cap_c4); end
    load(2'd1, 4'd7, 8'd7);
    load(2'd2, 4'd3, 8'd3);
    exec(OP_GT, 2'd2, 2'd1, 2'd0, lat);
    n_tests++; if (cap_d4 !== 4'd0 || cap_d8 !== 8'd0) begin n_fail++; $display("FAIL gt_false got %h/%h want 0/0", cap_d4, cap_d8); end
    exec(OP_GT, 2'd1, 2'd2, 2'd0, lat);
    n_tests++; if (cap_d4 !== 4'd1 || cap_d8 !== 8'd1) begin n_fail++; $display("FAIL gt_true got %h/%h want 1/1", cap_d4, cap_d8); end
  endtask

  task automatic test_back_to_back;
    load(2'd1, 4'd7, 8'd7);
    load(2'd2, 4'd3, 8'd3);
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = OP_ADD; in_rs = 2'd1; in_rt = 2'd2; in_rd = 2'd3;
    @(negedge clk);
    n_tests++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", rdy4); end
    in_rs = 2'd3; in_rt = 2'd3; in_rd = 2'd3;
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++; if (ov4 !== 1'b1 || od4 !== 4'd10) begin n_fail++; $display("FAIL b2b_first got v=%b d=%0d want 1 10", ov4, od4); end
    @(negedge clk);
    n_tests++; if (ov4 !== 1'b1 || od4 !== 4'd4 || oc4 !== 1'b1) begin n_fail++; $display("FAIL b2b_second got v=%b d=%0d c=%b want 1 4 1", ov4, od4, oc4); end
    n_tests++; if (ov8 !== 1'b1 || od8 !== 8'd20 || oc8 !== 1'b0) begin n_fail++; $display("FAIL b2b_second_w8 got v=%b d=%0d c=%b want 1 20 0", ov8, od8, oc8); end
    @(negedge clk);
    n_tests++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got v=%b want 0", ov4); end
  endtask

  task automatic test_stall;
    load(2'd0, 4'd0, 8'd0);
    load(2'd1, 4'd1, 8'd1);
    load(2'd2, 4'd2, 8'd2);
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = OP_ADD; in_rs = 2'd1; in_rt = 2'd2; in_rd = 2'd3;
    @(negedge clk);
    in_rs = 2'd0; in_rt = 2'd1; in_rd = 2'd0;
    @(negedge clk);
    n_tests++; if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL stall_ready_after2 got %b want 0", rdy4); end
    in_rs = 2'd0; in_rt = 2'd0; in_rd = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (rdy4 !== 1'b0 || ov4 !== 1'b1 || od4 !== 4'd3 || ord4 !== 2'd3) begin
        n_fail++; $display("FAIL stall_hold%0d got rdy=%b v=%b d=%0d rd=%0d want 0 1 3 3", i, rdy4, ov4, od4, ord4);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++; if (ov4 !== 1'b1 || od4 !== 4'd1 || ord4 !== 2'd0) begin n_fail++; $display("FAIL stall_rel2 got v=%b d=%0d rd=%0d want 1 1 0", ov4, od4, ord4); end
    @(negedge clk);
    n_tests++; if (ov4 !== 1'b1 || od4 !== 4'd2 || ord4 !== 2'd2) begin n_fail++; $display("FAIL stall_rel3 got v=%b d=%0d rd=%0d want 1 2 2", ov4, od4, ord4); end
    @(negedge clk);
    n_tests++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL stall_nodup got v=%b want 0", ov4); end
  endtask

  task automatic test_ld_collide;
    int lat;
    load(2'd1, 4'd7, 8'd7);
    load(2'd2, 4'd3, 8'd3);
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = OP_ADD; in_rs = 2'd1; in_rt = 2'd2; in_rd = 2'd3;
    @(negedge clk);
    in_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 2'd3; ld_d4 = 4'd5; ld_d8 = 8'd5;
    @(negedge clk);
    ld_en = 1'b0;
    n_tests++; if (ov4 !== 1'b1 || od4 !== 4'd10) begin n_fail++; $display("FAIL collide_out got v=%b d=%0d want 1 10", ov4, od4); end
    @(negedge clk);
    exec(OP_OR, 2'd3, 2'd3, 2'd0, lat);
    n_tests++; if (cap_d4 !== 4'd10 || cap_d8 !== 8'd10) begin n_fail++; $display("FAIL collide_r3 got %0d/%0d want 10/10", cap_d4, cap_d8); end
  endtask

  task automatic test_reset_midflight;
    int lat;
    load(2'd0, 4'd1, 8'd1);
    load(2'd1, 4'd2, 8'd2);
    load(2'd2, 4'd3, 8'd3);
    load(2'd3, 4'd4, 8'd4);
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = OP_ADD; in_rs = 2'd0; in_rt = 2'd1; in_rd = 2'd3;
    @(negedge clk);
    in_rs = 2'd2; in_rt = 2'd3; in_rd = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++; if (ov4 !== 1'b1 || od4 !== 4'd3) begin n_fail++; $display("FAIL midrst_pre got v=%b d=%0d want 1 3", ov4, od4); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (ov4 !== 1'b0 || ov8 !== 1'b0 || rdy4 !== 1'b1 || od4 !== 4'd0) begin n_fail++; $display("FAIL midrst_async got v=%b/%b rdy=%b d=%0d want 0/0 1 0", ov4, ov8, rdy4, od4); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL midrst_flushed got v=%b want 0", ov4); end
    exec(OP_OR, 2'd0, 2'd1, 2'd0, lat);
    n_tests++; if (cap_d4 !== 4'd0 || cap_d8 !== 8'd0) begin n_fail++; $display("FAIL midrst_rf01 got %h/%h want 0", cap_d4, cap_d8); end
    exec(OP_OR, 2'd2, 2'd3, 2'd2, lat);
    n_tests++; if (cap_d4 !== 4'd0 || cap_d8 !== 8'd0) begin n_fail++; $display("FAIL midrst_rf23 got %h/%h want 0", cap_d4, cap_d8); end
  endtask

  task automatic test_sweep4;
    int lat;
    logic [8:0] e4, e8;
    out_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        load(2'd0, 4'(a), 8'(a));
        load(2'd1, 4'(b), 8'(b));
        for (int op = 0; op < 8; op++) begin
          exec(3'(op), 2'd0, 2'd1, 2'd2, lat);
          e4 = model(4, op, a, b);
          e8 = model(8, op, a, b);
          n_tests++;
          if (lat !== 1 || cap_d4 !== e4[3:0] || cap_c4 !== e4[8]) begin
            n_fail++; $display("FAIL sweep4 op=%0d a=%0d b=%0d got %h/%b lat=%0d want %h/%b lat=1", op, a, b, cap_d4, cap_c4, lat, e4[3:0], e4[8]);
          end
          n_tests++;
          if (cap_d8 !== e8[7:0] || cap_c8 !== e8[8]) begin
            n_fail++; $display("FAIL sweep4_w8 op=%0d a=%0d b=%0d got %h/%b want %h/%b", op, a, b, cap_d8, cap_c8, e8[7:0], e8[8]);
          end
        end
      end
    end
  endtask

  task automatic test_sweep8;
    int lat;
    logic [8:0] e8;
    logic [7:0] vals [10];
    vals = '{8'h00, 8'h01, 8'h02, 8'h7f, 8'h80, 8'hfe, 8'hff, 8'h55, 8'haa, 8'h3c};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 10; j++) begin
        load(2'd0, vals[i][3:0], vals[i]);
        load(2'd1, vals[j][3:0], vals[j]);
        for (int op = 0; op < 8; op++) begin
          exec(3'(op), 2'd0, 2'd1, 2'd2, lat);
          e8 = model(8, op, int'(vals[i]), int'(vals[j]));
          n_tests++;
          if (lat !== 1 || cap_d8 !== e8[7:0] || cap_c8 !== e8[8]) begin
            n_fail++; $display("FAIL sweep8 op=%0d a=%h b=%h got %h/%b lat=%0d want %h/%b", op, vals[i], vals[j], cap_d8, cap_c8, lat, e8[7:0], e8[8]);
          end
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    ld_en = 1'b0; ld_addr = 2'd0; ld_d4 = 4'd0; ld_d8 = 8'd0;
    in_valid = 1'b0; in_sel = 3'd0; in_rs = 2'd0; in_rt = 2'd0; in_rd = 2'd0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_arith;
    test_logic_shift;
    test_back_to_back;
    test_stall;
    test_ld_collide;
    test_reset_midflight;
    test_sweep4;
    test_sweep8;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
